// File: rtl/stream_unpacker_pkg.sv
// Shared definitions for the stream unpacker slice.
//  - PIX_W / PIX_BYTES : output pixel geometry (24-bit RGB, 3 bytes)
//  - R_IDX/G_IDX/B_IDX : position of each colour byte inside a pixel's 3 bytes
//  - tbyte_t           : one buffered byte with its start-of-frame / end-of-line tags
//  - calc_strb_w / calc_buf_bytes : derive byte-lane count and buffer depth from tdata width
package stream_unpacker_pkg;

   localparam int PIX_W     = 24;
   localparam int PIX_BYTES = 3;

   // Byte 0 (lowest address) is blue, byte 2 is red.
   localparam int B_IDX = 0;
   localparam int G_IDX = 1;
   localparam int R_IDX = 2;

   typedef struct packed {
      logic       sof;
      logic       last;
      logic [7:0] data;
   } tbyte_t;

   function automatic int calc_strb_w(input int dw);
      return dw / 8;
   endfunction

   // Two full beats plus the two leftover bytes a pixel can leave behind.
   function automatic int calc_buf_bytes(input int dw);
      return 2 * (dw / 8) + 2;
   endfunction

endpackage

// File: rtl/stream_unpacker_byte_realign_buf.sv
// Tagged byte shift buffer. Entry 0 is the oldest byte. Each cycle it can drop the
// three oldest bytes (pop) and append up to STRB_W new bytes (push) behind whatever
// remains after the drop.
// Ports:
//  clk, rst_n      clock, asynchronous active-low reset
//  push            append push_nkeep bytes from push_data (byte 0 first)
//  push_data       incoming byte lanes
//  push_nkeep      number of lanes to append (0..STRB_W)
//  push_sof        tag the first appended byte as start of frame
//  push_last       tag the final appended byte as end of line
//  pop             discard entries 0..2 (caller guarantees occ >= 3)
//  occ             current occupancy
//  occ_after_pop   occupancy once this cycle's pop is applied
//  head_data       {entry2, entry1, entry0} data bytes as an RGB pixel
//  head_sof        sof tag of entry 0
//  head_last       last tag of entry 2
module byte_realign_buf
   import stream_unpacker_pkg::*;
#(
   parameter int STRB_W    = 4,
   parameter int BUF_BYTES = 10,
   parameter int OCC_W     = 4,
   parameter int KEEP_W    = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [8*STRB_W-1:0]   push_data,
   input  logic [KEEP_W-1:0]     push_nkeep,
   input  logic                  push_sof,
   input  logic                  push_last,
   input  logic                  pop,
   output logic [OCC_W-1:0]      occ,
   output logic [OCC_W-1:0]      occ_after_pop,
   output logic [PIX_W-1:0]      head_data,
   output logic                  head_sof,
   output logic                  head_last
);

   tbyte_t [BUF_BYTES-1:0] buf_reg;
   tbyte_t [BUF_BYTES-1:0] buf_next;
   logic   [OCC_W-1:0]     occ_reg;
   logic   [OCC_W-1:0]     occ_next;

   assign occ_after_pop = occ_reg - (pop ? OCC_W'(PIX_BYTES) : '0);
   assign occ_next      = occ_after_pop + (push ? OCC_W'(push_nkeep) : '0);

   for (genvar gi = 0; gi < BUF_BYTES; gi++) begin : g_entry
      tbyte_t shifted;
      tbyte_t entry_next;

      if (gi + PIX_BYTES < BUF_BYTES) begin : g_shift
         assign shifted = pop ? buf_reg[gi+PIX_BYTES] : buf_reg[gi];
      end else begin : g_top
         assign shifted = pop ? tbyte_t'('0) : buf_reg[gi];
      end

      // Appended lane k lands at occ_after_pop + k, so a pop and a push in the
      // same cycle compose without a bubble.
      always_comb begin
         entry_next = shifted;
         for (int k = 0; k < STRB_W; k++) begin
            if (push && (k < int'(push_nkeep)) && (int'(occ_after_pop) + k == gi)) begin
               entry_next.data = push_data[8*k +: 8];
               entry_next.sof  = push_sof && (k == 0);
               entry_next.last = push_last && (k == int'(push_nkeep) - 1);
            end
         end
      end

      assign buf_next[gi] = entry_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_reg <= '0;
         occ_reg <= '0;
      end else begin
         buf_reg <= buf_next;
         occ_reg <= occ_next;
      end
   end

   assign occ       = occ_reg;
   assign head_data = {buf_reg[R_IDX].data, buf_reg[G_IDX].data, buf_reg[B_IDX].data};
   assign head_sof  = buf_reg[0].sof;
   assign head_last = buf_reg[2].last;

endmodule

// File: rtl/stream_unpacker.sv
// Unpacks a dense 24-bit RGB byte stream (pixels straddling beats) into one pixel per
// handshake. SOF comes from the input tuser tag; EOL is regenerated from column/row
// counters, and input tlast is cross-checked against it (sticky err_eol).
// Ports:
//  clk, rst_n                     clock, asynchronous active-low reset
//  s_axis_tvalid/tready           input beat handshake
//  s_axis_tdata/tkeep             packed bytes and LSB-contiguous byte enables
//  s_axis_tlast/tuser             end of line / start of frame from the DMA
//  m_pix_valid/ready              output pixel handshake
//  m_pix_data                     {R,G,B} pixel
//  m_pix_sof/m_pix_eol            first pixel of frame / last pixel of line
//  frame_done                     one-cycle pulse after the frame's final pixel
//  err_eol                        sticky tlast-vs-counter disagreement, cleared by SOF
module stream_unpacker
   import stream_unpacker_pkg::*;
#(
   parameter int AXISIN_DATA_WIDTH = 32,
   parameter int SRC_IMG_WIDTH     = 960,
   parameter int SRC_IMG_HEIGHT    = 540
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic [AXISIN_DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic [AXISIN_DATA_WIDTH/8-1:0]    s_axis_tkeep,
   input  logic                              s_axis_tlast,
   input  logic                              s_axis_tuser,
   output logic                              m_pix_valid,
   input  logic                              m_pix_ready,
   output logic [PIX_W-1:0]                  m_pix_data,
   output logic                              m_pix_sof,
   output logic                              m_pix_eol,
   output logic                              frame_done,
   output logic                              err_eol
);

   localparam int STRB_W    = calc_strb_w(AXISIN_DATA_WIDTH);
   localparam int BUF_BYTES = calc_buf_bytes(AXISIN_DATA_WIDTH);
   localparam int OCC_W     = $clog2(BUF_BYTES + 1);
   localparam int KEEP_W    = $clog2(STRB_W + 1);
   localparam int COL_W     = (SRC_IMG_WIDTH  > 1) ? $clog2(SRC_IMG_WIDTH)  : 1;
   localparam int ROW_W     = (SRC_IMG_HEIGHT > 1) ? $clog2(SRC_IMG_HEIGHT) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(SRC_IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SRC_IMG_HEIGHT - 1);

   logic [OCC_W-1:0]  occ;
   logic [OCC_W-1:0]  occ_after_pop;
   logic [KEEP_W-1:0] keep_run;
   logic              gap_seen;
   logic              push;
   logic              pop;
   logic              head_sof;
   logic              head_last;

   logic [COL_W-1:0]  col_reg, col_next;
   logic [ROW_W-1:0]  row_reg, row_next;
   logic              err_reg, err_next;
   logic              frame_done_reg, frame_done_next;

   // Only the run of set enables starting at lane 0 is taken; anything after a gap is ignored.
   always_comb begin
      keep_run = '0;
      gap_seen = 1'b0;
      for (int k = 0; k < STRB_W; k++) begin
         if (!s_axis_tkeep[k]) begin
            gap_seen = 1'b1;
         end else if (!gap_seen) begin
            keep_run = keep_run + KEEP_W'(1);
         end
      end
   end

   assign m_pix_valid = (occ >= OCC_W'(PIX_BYTES));
   assign pop         = m_pix_valid && m_pix_ready;

   // Room is judged after this cycle's pop, so a full buffer still takes a beat
   // in the same cycle a pixel leaves.
   assign s_axis_tready = ({1'b0, occ_after_pop} + (OCC_W+1)'(STRB_W)) <= (OCC_W+1)'(BUF_BYTES);
   assign push          = s_axis_tvalid && s_axis_tready;

   byte_realign_buf #(
      .STRB_W    (STRB_W),
      .BUF_BYTES (BUF_BYTES),
      .OCC_W     (OCC_W),
      .KEEP_W    (KEEP_W)
   ) u_buf (
      .clk           (clk),
      .rst_n         (rst_n),
      .push          (push),
      .push_data     (s_axis_tdata),
      .push_nkeep    (keep_run),
      .push_sof      (s_axis_tuser),
      .push_last     (s_axis_tlast),
      .pop           (pop),
      .occ           (occ),
      .occ_after_pop (occ_after_pop),
      .head_data     (m_pix_data),
      .head_sof      (head_sof),
      .head_last     (head_last)
   );

   assign m_pix_sof  = head_sof;
   assign m_pix_eol  = (col_reg == COL_LAST);
   assign frame_done = frame_done_reg;
   assign err_eol    = err_reg;

   always_comb begin
      col_next        = col_reg;
      row_next        = row_reg;
      err_next        = err_reg;
      frame_done_next = 1'b0;
      if (pop) begin
         if (head_sof) begin
            // The SOF pixel itself is column 0, so counting resumes at 1.
            col_next = COL_W'(1);
            row_next = '0;
            err_next = 1'b0;
         end else begin
            // tlast tags the pixel's final byte, which is entry 2.
            if (head_last != m_pix_eol) begin
               err_next = 1'b1;
            end
            if (m_pix_eol) begin
               col_next = '0;
               if (row_reg == ROW_LAST) begin
                  row_next        = '0;
                  frame_done_next = 1'b1;
               end else begin
                  row_next = row_reg + ROW_W'(1);
               end
            end else begin
               col_next = col_reg + COL_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_reg        <= '0;
         row_reg        <= '0;
         err_reg        <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         col_reg        <= col_next;
         row_reg        <= row_next;
         err_reg        <= err_next;
         frame_done_reg <= frame_done_next;
      end
   end

endmodule

// File: tb/tb_stream_unpacker.sv
// Randomized bench for stream_unpacker (32-bit input, 4x2 pixel frames). A byte-queue
// reference model predicts every output each cycle; a short directed opening checks the
// spec example pixels and the back-pressure fill level, and a mid-run reset is applied.
module tb_stream_unpacker;

   localparam int DW     = 32;
   localparam int STRB   = DW / 8;
   localparam int BUFB   = 2 * STRB + 2;
   localparam int W      = 4;
   localparam int H      = 2;
   localparam int LINE_B = 3 * W;
   localparam int NCYC   = 4000;
   localparam int RST_AT = 2500;

   logic            clk;
   logic            rst_n;
   logic            s_axis_tvalid;
   logic            s_axis_tready;
   logic [DW-1:0]   s_axis_tdata;
   logic [STRB-1:0] s_axis_tkeep;
   logic            s_axis_tlast;
   logic            s_axis_tuser;
   logic            m_pix_valid;
   logic            m_pix_ready;
   logic [23:0]     m_pix_data;
   logic            m_pix_sof;
   logic            m_pix_eol;
   logic            frame_done;
   logic            err_eol;

   stream_unpacker #(
      .AXISIN_DATA_WIDTH (DW),
      .SRC_IMG_WIDTH     (W),
      .SRC_IMG_HEIGHT    (H)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .m_pix_valid   (m_pix_valid),
      .m_pix_ready   (m_pix_ready),
      .m_pix_data    (m_pix_data),
      .m_pix_sof     (m_pix_sof),
      .m_pix_eol     (m_pix_eol),
      .frame_done    (frame_done),
      .err_eol       (err_eol)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the byte stream as a queue, and the pixel position in the frame.
   typedef struct {
      logic [7:0] b;
      bit         sof;
      bit         last;
   } mbyte_t;

   mbyte_t q[$];
   int     m_pix;      // pixel index in frame (row*W + col)
   bit     m_err;
   bit     m_fd;
   int     pix_seen;

   // Stream generator state (well-formed lines unless deliberately corrupted).
   int     g_line_pos;
   int     g_line;
   int     g_bval;
   int     beat_n;
   bit     pending;

   task automatic model_reset();
      q.delete();
      m_pix = 0;
      m_err = 0;
      m_fd  = 0;
   endtask

   task automatic gen_reset();
      g_line_pos = 0;
      g_line     = 0;
      pending    = 0;
   endtask

   task automatic make_beat(input bit directed);
      int n;
      n = directed ? STRB : int'($urandom_range(1, STRB));
      if (n > LINE_B - g_line_pos) n = LINE_B - g_line_pos;
      beat_n       = n;
      s_axis_tkeep = '0;
      for (int k = 0; k < STRB; k++) begin
         if (k < n) s_axis_tkeep[k] = 1'b1;
         s_axis_tdata[8*k +: 8] = directed ? 8'(g_bval + k) : 8'($urandom);
      end
      // A stray enable beyond a gap must be ignored by the DUT.
      if (!directed && n <= STRB - 2 && $urandom_range(0, 7) == 0) s_axis_tkeep[n+1] = 1'b1;
      s_axis_tuser = (g_line_pos == 0 && g_line == 0);
      s_axis_tlast = (g_line_pos + n == LINE_B);
      if (!directed && $urandom_range(0, 39) == 0) s_axis_tlast = !s_axis_tlast;
      if (!directed && $urandom_range(0, 49) == 0) s_axis_tuser = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tready"}, 32'(s_axis_tready), 32'd1);
      chk({tag, "_valid"},  32'(m_pix_valid),   32'd0);
      chk({tag, "_sof"},    32'(m_pix_sof),     32'd0);
      chk({tag, "_eol"},    32'(m_pix_eol),     32'd0);
      chk({tag, "_fdone"},  32'(frame_done),    32'd0);
      chk({tag, "_err"},    32'(err_eol),       32'd0);
      chk({tag, "_data"},   32'(m_pix_data),    32'd0);
   endtask

   logic [23:0] first_px [4];

   initial begin
      bit     directed;
      bit     exp_valid;
      bit     exp_pop;
      bit     exp_tready;
      bit     exp_eol;
      bit     fd_next;
      int     run;
      mbyte_t nb;

      first_px[0] = 24'h020100;
      first_px[1] = 24'h050403;
      first_px[2] = 24'h080706;
      first_px[3] = 24'h0B0A09;

      rst_n         = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      m_pix_ready   = 1'b0;
      g_bval        = 0;
      pix_seen      = 0;
      model_reset();
      gen_reset();

      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         rst_n = 1'b1;

         if (cyc == RST_AT) begin
            // Mid-stream asynchronous reset: everything drops immediately.
            s_axis_tvalid = 1'b0;
            m_pix_ready   = 1'b0;
            rst_n         = 1'b0;
            #1;
            check_reset_outputs("midrst");
            model_reset();
            gen_reset();
            continue;
         end

         // Opening: 3 full beats drained with ready=1, then back-pressure with ready=0.
         directed = (cyc < 12);
         if (cyc < 6)       m_pix_ready = 1'b1;
         else if (cyc < 12) m_pix_ready = 1'b0;
         else               m_pix_ready = ($urandom_range(0, 3) != 0);

         if (!pending) begin
            if (directed ? (cyc < 3 || cyc >= 6) : ($urandom_range(0, 3) != 0)) begin
               make_beat(directed);
               s_axis_tvalid = 1'b1;
               pending       = 1;
            end else begin
               s_axis_tvalid = 1'b0;
            end
         end

         #1;
         exp_valid  = (q.size() >= 3);
         exp_pop    = exp_valid && m_pix_ready;
         exp_tready = (q.size() - (exp_pop ? 3 : 0) + STRB) <= BUFB;
         exp_eol    = ((m_pix % W) == W - 1);

         chk("tready",     32'(s_axis_tready), 32'(exp_tready));
         chk("pix_valid",  32'(m_pix_valid),   32'(exp_valid));
         chk("pix_eol",    32'(m_pix_eol),     32'(exp_eol));
         chk("err_eol",    32'(err_eol),       32'(m_err));
         chk("frame_done", 32'(frame_done),    32'(m_fd));
         if (cyc == 8) chk("tready_full", 32'(s_axis_tready), 32'd0);
         if (exp_valid) begin
            chk("pix_data", 32'(m_pix_data), 32'({q[2].b, q[1].b, q[0].b}));
            chk("pix_sof",  32'(m_pix_sof),  32'(q[0].sof));
         end
         if (exp_pop && pix_seen < 4) begin
            chk("first_px", 32'(m_pix_data), 32'(first_px[pix_seen]));
         end

         // Advance the model to the state after this clock edge.
         fd_next = 0;
         if (exp_pop) begin
            pix_seen++;
            if (q[0].sof) begin
               m_pix = 1;
               m_err = 0;
            end else begin
               if (q[2].last != exp_eol) m_err = 1;
               m_pix++;
               if (m_pix == W * H) begin
                  m_pix   = 0;
                  fd_next = 1;
               end
            end
            void'(q.pop_front());
            void'(q.pop_front());
            void'(q.pop_front());
         end
         m_fd = fd_next;

         if (s_axis_tvalid && exp_tready) begin
            run = 0;
            while (run < STRB && s_axis_tkeep[run]) run++;
            for (int k = 0; k < run; k++) begin
               nb.b    = s_axis_tdata[8*k +: 8];
               nb.sof  = s_axis_tuser && (k == 0);
               nb.last = s_axis_tlast && (k == run - 1);
               q.push_back(nb);
            end
            g_line_pos += beat_n;
            g_bval     += beat_n;
            if (g_line_pos >= LINE_B) begin
               g_line_pos = 0;
               g_line     = (g_line + 1) % H;
            end
            pending = 0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
